// File: rtl/dose_alert_controller.sv
// Dose alert controller: arms on a scheduled BCD time, alerts with a blinking buzzer,
// handles acknowledge and bounded snooze, and counts missed doses with a one-deep pending slot.
module dose_alert_controller #(
  parameter int ALERT_TIMEOUT_S = 300,
  parameter int SNOOZE_S        = 60,
  parameter int MAX_SNOOZE      = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_1hz,
  input  logic [23:0] time_bcd,
  input  logic        dose_valid,
  input  logic [23:0] dose_time_bcd,
  input  logic [3:0]  dose_id,
  input  logic        ack,
  input  logic        snooze,
  input  logic        clear_missed,
  output logic [1:0]  state,
  output logic        alert_active,
  output logic        buzzer,
  output logic [3:0]  alert_id,
  output logic        dose_taken,
  output logic        dose_missed,
  output logic [3:0]  missed_count,
  output logic [1:0]  snooze_count
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ARMED    = 2'd1;
  localparam logic [1:0] ALERTING = 2'd2;
  localparam logic [1:0] SNOOZED  = 2'd3;

  localparam int TMAX = (ALERT_TIMEOUT_S > SNOOZE_S) ? ALERT_TIMEOUT_S : SNOOZE_S;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] ALERT_LIM  = TW'(ALERT_TIMEOUT_S);
  localparam logic [TW-1:0] SNOOZE_LIM = TW'(SNOOZE_S);
  localparam logic [1:0]    SNZ_MAX    = 2'(MAX_SNOOZE);

  logic [23:0]   schedTime;
  logic [TW-1:0] alertTimer;
  logic [TW-1:0] snoozeTimer;
  logic          pendValid;
  logic [23:0]   pendTime;
  logic [3:0]    pendId;

  logic [TW-1:0] alertInc;
  logic [TW-1:0] snoozeInc;
  logic          missEvent;

  assign alertInc     = alertTimer + 1'b1;
  assign snoozeInc    = snoozeTimer + 1'b1;
  assign alert_active = (state == ALERTING);

  // ack outranks the timeout, so a tick that coincides with ack never counts as a miss.
  assign missEvent = (state == ALERTING) && !ack && tick_1hz && (alertInc == ALERT_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      schedTime    <= '0;
      alert_id     <= '0;
      alertTimer   <= '0;
      snoozeTimer  <= '0;
      snooze_count <= '0;
      buzzer       <= 1'b0;
      dose_taken   <= 1'b0;
      dose_missed  <= 1'b0;
      pendValid    <= 1'b0;
      pendTime     <= '0;
      pendId       <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only; the pulse defaults
      // below are overridden later in the same block, which is safe because the last NBA wins.
      dose_taken  <= 1'b0;
      dose_missed <= 1'b0;

      case (state)
        IDLE: begin
          buzzer <= 1'b0;
          if (dose_valid) begin
            schedTime <= dose_time_bcd;
            alert_id  <= dose_id;
            pendValid <= 1'b0;
            state     <= ARMED;
          end else if (pendValid) begin
            schedTime <= pendTime;
            alert_id  <= pendId;
            pendValid <= 1'b0;
            state     <= ARMED;
          end
        end

        ARMED: begin
          // The match uses the schedule held before any replacement this cycle.
          if (dose_valid) begin
            schedTime <= dose_time_bcd;
            alert_id  <= dose_id;
          end
          if (time_bcd == schedTime) begin
            state        <= ALERTING;
            alertTimer   <= '0;
            snooze_count <= '0;
            buzzer       <= 1'b1;
          end
        end

        ALERTING: begin
          if (dose_valid) begin
            pendValid <= 1'b1;
            pendTime  <= dose_time_bcd;
            pendId    <= dose_id;
          end
          if (ack) begin
            state      <= IDLE;
            dose_taken <= 1'b1;
            buzzer     <= 1'b0;
          end else if (missEvent) begin
            state       <= IDLE;
            dose_missed <= 1'b1;
            buzzer      <= 1'b0;
          end else if (snooze && (snooze_count < SNZ_MAX)) begin
            state        <= SNOOZED;
            snooze_count <= snooze_count + 1'b1;
            snoozeTimer  <= '0;
            buzzer       <= 1'b0;
          end else if (tick_1hz) begin
            alertTimer <= alertInc;
            buzzer     <= ~buzzer;
          end
        end

        default: begin // SNOOZED
          if (dose_valid) begin
            pendValid <= 1'b1;
            pendTime  <= dose_time_bcd;
            pendId    <= dose_id;
          end
          if (ack) begin
            state      <= IDLE;
            dose_taken <= 1'b1;
            buzzer     <= 1'b0;
          end else if (tick_1hz) begin
            if (snoozeInc == SNOOZE_LIM) begin
              state      <= ALERTING;
              alertTimer <= '0;
              buzzer     <= 1'b1;
            end else begin
              snoozeTimer <= snoozeInc;
            end
          end
        end
      endcase
    end
  end

  // A miss landing in the same cycle as a clear leaves exactly one recorded miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      missed_count <= '0;
    end else if (clear_missed) begin
      missed_count <= missEvent ? 4'd1 : 4'd0;
    end else if (missEvent && (missed_count != 4'd15)) begin
      missed_count <= missed_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_dose_alert_controller.sv
// Directed bench for dose_alert_controller: expectations are queued as stimulus is driven
// and compared after the following clock edge.
module tb_dose_alert_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick_1hz;
  logic [23:0] time_bcd;
  logic        dose_valid;
  logic [23:0] dose_time_bcd;
  logic [3:0]  dose_id;
  logic        ack;
  logic        snooze;
  logic        clear_missed;
  logic [1:0]  state;
  logic        alert_active;
  logic        buzzer;
  logic [3:0]  alert_id;
  logic        dose_taken;
  logic        dose_missed;
  logic [3:0]  missed_count;
  logic [1:0]  snooze_count;

  dose_alert_controller #(
    .ALERT_TIMEOUT_S(5),
    .SNOOZE_S       (3),
    .MAX_SNOOZE     (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_1hz     (tick_1hz),
    .time_bcd     (time_bcd),
    .dose_valid   (dose_valid),
    .dose_time_bcd(dose_time_bcd),
    .dose_id      (dose_id),
    .ack          (ack),
    .snooze       (snooze),
    .clear_missed (clear_missed),
    .state        (state),
    .alert_active (alert_active),
    .buzzer       (buzzer),
    .alert_id     (alert_id),
    .dose_taken   (dose_taken),
    .dose_missed  (dose_missed),
    .missed_count (missed_count),
    .snooze_count (snooze_count)
  );

  always #5 clk = ~clk;

  typedef enum int {F_STATE, F_ACTIVE, F_BUZZ, F_ID, F_TAKEN, F_MISSED, F_MCOUNT, F_SCOUNT} field_e;

  typedef struct {
    string      tag;
    field_e     f;
    logic [7:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [7:0] observe(field_e f);
    case (f)
      F_STATE:  return {6'd0, state};
      F_ACTIVE: return {7'd0, alert_active};
      F_BUZZ:   return {7'd0, buzzer};
      F_ID:     return {4'd0, alert_id};
      F_TAKEN:  return {7'd0, dose_taken};
      F_MISSED: return {7'd0, dose_missed};
      F_MCOUNT: return {4'd0, missed_count};
      default:  return {6'd0, snooze_count};
    endcase
  endfunction

  task automatic ex(input string tag, input field_e f, input int v);
    exp_t e;
    e.tag = tag;
    e.f   = f;
    e.exp = v[7:0];
    sbq.push_back(e);
  endtask

  task automatic sample();
    exp_t       e;
    logic [7:0] obs;
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      obs = observe(e.f);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  // One clock edge: compare queued expectations just after it, then drop one-cycle pulses.
  task automatic cyc();
    @(posedge clk);
    #1;
    sample();
    tick_1hz     = 1'b0;
    dose_valid   = 1'b0;
    ack          = 1'b0;
    snooze       = 1'b0;
    clear_missed = 1'b0;
  endtask

  task automatic arm(input logic [23:0] t, input logic [3:0] id);
    dose_valid    = 1'b1;
    dose_time_bcd = t;
    dose_id       = id;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int expMiss;
    rst_n = 1'b0;
    tick_1hz = 1'b0; dose_valid = 1'b0; ack = 1'b0; snooze = 1'b0; clear_missed = 1'b0;
    time_bcd = 24'h120000; dose_time_bcd = '0; dose_id = '0;

    repeat (2) @(posedge clk);
    #1;
    ex("rst_state", F_STATE, 0); ex("rst_active", F_ACTIVE, 0); ex("rst_buzz", F_BUZZ, 0);
    ex("rst_id", F_ID, 0); ex("rst_mcount", F_MCOUNT, 0); ex("rst_scount", F_SCOUNT, 0);
    sample();
    rst_n = 1'b1;

    // Reset asserted in the middle of an alert.
    time_bcd = 24'h075959; arm(24'h080000, 4'd5);
    ex("t1_armed", F_STATE, 1); ex("t1_armed_id", F_ID, 5);
    cyc();
    time_bcd = 24'h080000;
    ex("t1_alert", F_STATE, 2); ex("t1_alert_buzz", F_BUZZ, 1);
    cyc();
    rst_n = 1'b0;
    #1;
    ex("t1_rst_state", F_STATE, 0); ex("t1_rst_active", F_ACTIVE, 0); ex("t1_rst_buzz", F_BUZZ, 0);
    ex("t1_rst_id", F_ID, 0); ex("t1_rst_taken", F_TAKEN, 0); ex("t1_rst_missed", F_MISSED, 0);
    ex("t1_rst_scount", F_SCOUNT, 0); ex("t1_rst_mcount", F_MCOUNT, 0);
    sample();
    ex("t1_rst_hold_missed", F_MISSED, 0); ex("t1_rst_hold_state", F_STATE, 0);
    cyc();
    rst_n = 1'b1;

    // Arm and acknowledge, with the buzzer blinking per tick.
    time_bcd = 24'h075959; arm(24'h080000, 4'd5);
    ex("t2_armed", F_STATE, 1);
    cyc();
    ex("t2_wait", F_STATE, 1);
    cyc();
    time_bcd = 24'h080000;
    ex("t2_alert", F_STATE, 2); ex("t2_alert_id", F_ID, 5); ex("t2_buzz_on", F_BUZZ, 1);
    ex("t2_active", F_ACTIVE, 1); ex("t2_scount", F_SCOUNT, 0);
    cyc();
    time_bcd = 24'h080001;
    tick_1hz = 1'b1; ex("t2_tick1_buzz", F_BUZZ, 0);
    cyc();
    tick_1hz = 1'b1; ex("t2_tick2_buzz", F_BUZZ, 1);
    cyc();
    ack = 1'b1;
    ex("t2_ack_state", F_STATE, 0); ex("t2_ack_taken", F_TAKEN, 1); ex("t2_ack_buzz", F_BUZZ, 0);
    ex("t2_ack_active", F_ACTIVE, 0); ex("t2_ack_id", F_ID, 5);
    cyc();
    ex("t2_taken_drop", F_TAKEN, 0); ex("t2_idle", F_STATE, 0);
    cyc();

    // Missed doses: 16 timeouts saturate the counter at 15.
    for (int i = 0; i < 16; i++) begin
      time_bcd = 24'h095959; arm(24'h100000, 4'd7);
      ex("t3_armed", F_STATE, 1);
      cyc();
      time_bcd = 24'h100000;
      ex("t3_alert", F_STATE, 2);
      cyc();
      time_bcd = 24'h100001;
      for (int k = 1; k < 5; k++) begin
        tick_1hz = 1'b1;
        ex($sformatf("t3_tick%0d_state", k), F_STATE, 2);
        ex($sformatf("t3_tick%0d_missed", k), F_MISSED, 0);
        cyc();
      end
      expMiss = (i + 1 > 15) ? 15 : i + 1;
      tick_1hz = 1'b1;
      ex($sformatf("t3_miss%0d_state", i), F_STATE, 0);
      ex($sformatf("t3_miss%0d_pulse", i), F_MISSED, 1);
      ex($sformatf("t3_miss%0d_count", i), F_MCOUNT, expMiss);
      cyc();
      ex("t3_miss_drop", F_MISSED, 0);
      cyc();
    end

    // Clear coinciding with a miss leaves a count of one; a plain clear zeroes it.
    time_bcd = 24'h095959; arm(24'h100000, 4'd7);
    cyc();
    time_bcd = 24'h100000;
    cyc();
    time_bcd = 24'h100001;
    repeat (4) begin
      tick_1hz = 1'b1;
      cyc();
    end
    tick_1hz = 1'b1; clear_missed = 1'b1;
    ex("t3_clr_miss_pulse", F_MISSED, 1); ex("t3_clr_miss_count", F_MCOUNT, 1);
    cyc();
    clear_missed = 1'b1;
    ex("t3_clear", F_MCOUNT, 0);
    cyc();

    // Snooze limit.
    time_bcd = 24'h105959; arm(24'h110000, 4'd4);
    ex("t4_armed", F_STATE, 1);
    cyc();
    time_bcd = 24'h110000;
    ex("t4_alert", F_STATE, 2); ex("t4_scount0", F_SCOUNT, 0);
    cyc();
    time_bcd = 24'h110001;
    for (int k = 1; k <= 3; k++) begin
      snooze = 1'b1;
      ex($sformatf("t4_snz%0d_state", k), F_STATE, 3);
      ex($sformatf("t4_snz%0d_count", k), F_SCOUNT, k);
      ex($sformatf("t4_snz%0d_buzz", k), F_BUZZ, 0);
      ex($sformatf("t4_snz%0d_active", k), F_ACTIVE, 0);
      cyc();
      for (int t = 1; t < 3; t++) begin
        tick_1hz = 1'b1;
        ex($sformatf("t4_snz%0d_t%0d", k, t), F_STATE, 3);
        cyc();
      end
      tick_1hz = 1'b1;
      ex($sformatf("t4_realert%0d_state", k), F_STATE, 2);
      ex($sformatf("t4_realert%0d_buzz", k), F_BUZZ, 1);
      ex($sformatf("t4_realert%0d_active", k), F_ACTIVE, 1);
      cyc();
    end
    snooze = 1'b1;
    ex("t4_snz4_ignored", F_STATE, 2); ex("t4_snz4_count", F_SCOUNT, 3); ex("t4_snz4_buzz", F_BUZZ, 1);
    cyc();
    ack = 1'b1; snooze = 1'b1;
    ex("t4_ack_snz_state", F_STATE, 0); ex("t4_ack_snz_taken", F_TAKEN, 1);
    cyc();

    // Midnight wrap and the pending slot.
    time_bcd = 24'h235958; arm(24'h000000, 4'd2);
    ex("t5_armed", F_STATE, 1); ex("t5_armed_id", F_ID, 2);
    cyc();
    time_bcd = 24'h235959;
    ex("t5_pre_midnight", F_STATE, 1);
    cyc();
    time_bcd = 24'h000000;
    ex("t5_midnight_alert", F_STATE, 2); ex("t5_midnight_id", F_ID, 2);
    cyc();
    time_bcd = 24'h000005; arm(24'h000020, 4'd9);
    ex("t5_pend1_state", F_STATE, 2); ex("t5_pend1_id", F_ID, 2);
    cyc();
    arm(24'h000010, 4'd3);
    ex("t5_pend2_state", F_STATE, 2);
    cyc();
    ack = 1'b1;
    ex("t5_ack_state", F_STATE, 0); ex("t5_ack_taken", F_TAKEN, 1); ex("t5_ack_id", F_ID, 2);
    cyc();
    ex("t5_pend_armed", F_STATE, 1); ex("t5_pend_id", F_ID, 3);
    cyc();
    time_bcd = 24'h000009;
    ex("t5_pend_wait", F_STATE, 1);
    cyc();
    time_bcd = 24'h000010;
    ex("t5_pend_alert", F_STATE, 2); ex("t5_pend_alert_id", F_ID, 3); ex("t5_pend_buzz", F_BUZZ, 1);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dose_alert_controller.md
Name: dose_alert_controller

Overview:
- Sits downstream of the clock and next-pill monitor stages, beside the LCD/7-seg outputs.
- Accepts the next scheduled dose (BCD HHMMSS time and pill ID) and watches the running BCD time.
- At the scheduled time it raises an alert with a blinking buzzer/LED, and supports acknowledge and bounded snooze.
- Declares a dose missed after a timeout and keeps a saturating missed-dose count.

Parameters:
- ALERT_TIMEOUT_S, 300, ticks of alerting before the dose is declared missed (must be ≥1)
- SNOOZE_S, 60, ticks spent in snooze before re-alerting (must be ≥1)
- MAX_SNOOZE, 3, snoozes allowed per dose (1..3)

Ports:
- clk, input, 1, system clock
- rst_n, input, 1, asynchronous active-low reset
- tick_1hz, input, 1, one-cycle pulse per elapsed clock second (demo or real rate, chosen upstream)
- time_bcd, input, 24, current time HHMMSS in BCD
- dose_valid, input, 1, one-cycle pulse: new schedule entry on dose_time_bcd/dose_id
- dose_time_bcd, input, 24, scheduled dose time HHMMSS in BCD
- dose_id, input, 4, pill ID of the scheduled dose
- ack, input, 1, one-cycle shaped button pulse: dose taken
- snooze, input, 1, one-cycle shaped button pulse: snooze request
- clear_missed, input, 1, one-cycle pulse: zero missed_count
- state, output, 2, IDLE=0, ARMED=1, ALERTING=2, SNOOZED=3
- alert_active, output, 1, high in ALERTING
- buzzer, output, 1, blink output
- alert_id, output, 4, ID of the armed/alerting dose
- dose_taken, output, 1, one-cycle pulse on acknowledge
- dose_missed, output, 1, one-cycle pulse on timeout
- missed_count, output, 4, saturating count of missed doses
- snooze_count, output, 2, snoozes used on the current dose

Behaviour:
- Reset (async, rst_n=0) clears every register and output to 0, forces state=IDLE and clears the pending slot. This applies mid-alert or mid-snooze with no pulses emitted.
- All transitions are registered. Outputs change on the clk edge after the causing input.
- IDLE:
  - dose_valid → ARMED; latch dose_time_bcd into sched_time and dose_id into alert_id.
  - If the pending slot is valid, load it → ARMED and clear the slot.
- ARMED:
  - time_bcd == sched_time on any cycle → ALERTING; alert_timer=0, snooze_count=0, buzzer=1.
  - dose_valid in ARMED replaces sched_time/alert_id. The match is checked against the old value that cycle.
  - Midnight wrap (235959→000000) needs no special handling; the comparison is pure equality.
- ALERTING:
  - alert_active=1. Each tick_1hz toggles buzzer and increments alert_timer.
  - ack → IDLE; pulse dose_taken.
  - snooze, if snooze_count < MAX_SNOOZE → SNOOZED; snooze_count+1, snooze_timer=0, buzzer=0.
  - snooze at the limit is ignored.
  - A tick that makes alert_timer reach ALERT_TIMEOUT_S → IDLE; pulse dose_missed, missed_count+1 saturating at 15.
- SNOOZED:
  - alert_active=0, buzzer=0. Each tick increments snooze_timer.
  - Reaching SNOOZE_S → ALERTING with alert_timer=0 and buzzer=1.
  - ack in SNOOZED → IDLE with dose_taken pulse (early take).
- Priority within one cycle: ack > timeout > snooze > tick increment.
- clear_missed zeroes missed_count. If a dose_missed occurs in the same cycle, the result is 1.
- Pending slot (one deep):
  - dose_valid during ALERTING/SNOOZED stores the entry there; a later arrival overwrites it.
  - The slot is consumed on the IDLE cycle after the alert ends, so the next dose is ARMED two cycles after ack or timeout.
- Outputs on leaving ALERTING/SNOOZED: alert_id holds its value into IDLE; buzzer and alert_active drop to 0.
- Timers are sized to hold max(ALERT_TIMEOUT_S, SNOOZE_S). Ticks in IDLE and ARMED are ignored.

Test Plan:
- Reset mid-alert: arm 080000 id 5, alert fires, assert rst_n=0 → state=0, all outputs 0, no dose_missed pulse.
- Arm and acknowledge: dose 080000 id 5, drive time 075959 → 080000 → ALERTING next edge, alert_id=5, buzzer toggles per tick; ack → dose_taken one cycle, state=IDLE.
- Missed timeout with ALERT_TIMEOUT_S=5: alert, give 5 ticks, no ack → dose_missed on the 5th tick, missed_count 0→1. Repeat 16 times → missed_count saturates at 15; clear_missed → 0.
- Snooze limit with SNOOZE_S=3, MAX_SNOOZE=3:
  - Three snooze/3-tick cycles each return to ALERTING, with snooze_count reaching 3.
  - A fourth snooze is ignored (stays ALERTING).
  - Ack plus snooze in the same cycle → dose_taken, IDLE.
- Pending and midnight wrap:
  - Arm 000000 id 2 and step time 235959→000000 → ALERTING.
  - dose_valid 000010 id 3 during the alert; ack → IDLE, then ARMED two cycles after ack with alert_id=3.
  - At time 000010 → ALERTING.
